// File: rtl/ball_physics.sv
// ball_physics
// ----------------------------------------------------------------------------
// Ball motion engine for a two-paddle playfield. The ball waits at centre
// during a serve delay and then steps one cell per move period. It bounces
// off the top and bottom walls and off either paddle, and scores when it
// leaves through the left or right edge. Each paddle return shortens the
// move period down to a floor. A registered draw flag marks the ball cell
// for the scan position that was presented on the previous clock.
//
// Ports
//   i_Clk            sole clock, rising edge
//   i_Rst_L          asynchronous active-low reset
//   i_Game_Active    level; low returns the engine to IDLE
//   i_Col_Count_Div  scan column in game units
//   i_Row_Count_Div  scan row in game units
//   i_Paddle_Y_P1    top row of the left paddle (column 0)
//   i_Paddle_Y_P2    top row of the right paddle (column GAME_WIDTH-1)
//   o_Draw_Ball      ball cell at the scan position, one clock latency
//   o_Ball_X         ball column
//   o_Ball_Y         ball row
//   o_Score_P1       one-clock pulse: ball left through the right edge
//   o_Score_P2       one-clock pulse: ball left through the left edge
//   o_Hit            one-clock pulse: paddle return
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | game inactive; ball parked at centre, period at serve speed
// SERVE  | ball held at centre for SERVE_DELAY clocks
// PLAY   | ball moves one cell every Period clocks
// ----------------------------------------------------------------------------
module ball_physics #(
    parameter int GAME_WIDTH    = 40,
    parameter int GAME_HEIGHT   = 30,
    parameter int COORD_W       = 6,
    parameter int PADDLE_HEIGHT = 6,
    parameter int SPEED_START   = 1250000,
    parameter int SPEED_STEP    = 125000,
    parameter int SPEED_MIN     = 250000,
    parameter int SERVE_DELAY   = 25000000
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_Game_Active,
    input  logic [COORD_W-1:0] i_Col_Count_Div,
    input  logic [COORD_W-1:0] i_Row_Count_Div,
    input  logic [COORD_W-1:0] i_Paddle_Y_P1,
    input  logic [COORD_W-1:0] i_Paddle_Y_P2,
    output logic               o_Draw_Ball,
    output logic [COORD_W-1:0] o_Ball_X,
    output logic [COORD_W-1:0] o_Ball_Y,
    output logic               o_Score_P1,
    output logic               o_Score_P2,
    output logic               o_Hit
);

    // One counter serves both the serve delay and the move period, so it is
    // sized for whichever of the two is longer.
    localparam int CNT_MAX = (SERVE_DELAY > SPEED_START) ? SERVE_DELAY : SPEED_START;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PER_W   = $clog2(SPEED_START + 1);

    localparam logic [COORD_W-1:0] X_CENTRE  = COORD_W'(GAME_WIDTH / 2);
    localparam logic [COORD_W-1:0] Y_CENTRE  = COORD_W'(GAME_HEIGHT / 2);
    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(GAME_WIDTH - 1);
    localparam logic [COORD_W-1:0] X_HIT_R   = COORD_W'(GAME_WIDTH - 2);
    localparam logic [COORD_W-1:0] X_RET_R   = COORD_W'(GAME_WIDTH - 3);
    localparam logic [COORD_W-1:0] X_HIT_L   = COORD_W'(1);
    localparam logic [COORD_W-1:0] X_RET_L   = COORD_W'(2);
    localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(GAME_HEIGHT - 1);
    localparam logic [PER_W-1:0]   PER_START = PER_W'(SPEED_START);
    localparam logic [PER_W-1:0]   PER_FLOOR = PER_W'(SPEED_MIN);
    localparam logic [PER_W-1:0]   PER_STEP  = PER_W'(SPEED_STEP);
    localparam logic [CNT_W-1:0]   SERVE_END = CNT_W'(SERVE_DELAY - 1);
    localparam logic [COORD_W:0]   PAD_SPAN  = (COORD_W + 1)'(PADDLE_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [COORD_W-1:0]   ball_x, ball_x_next;
    logic [COORD_W-1:0]   ball_y, ball_y_next;
    logic                 dir_x, dir_x_next;
    logic                 dir_y, dir_y_next;
    logic [PER_W-1:0]     period, period_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic                 draw_q, draw_next;
    logic                 score_p1_q, score_p1_next;
    logic                 score_p2_q, score_p2_next;
    logic                 hit_q, hit_next;

    logic                 tick;
    logic                 on_p1;
    logic                 on_p2;
    logic [COORD_W:0]     y_ext;
    logic [COORD_W:0]     p1_top, p1_bot;
    logic [COORD_W:0]     p2_top, p2_bot;
    logic [PER_W-1:0]     period_faster;

    // Paddle span compare is done one bit wider so a paddle near the bottom
    // of the coordinate range cannot wrap around and catch a ball near row 0.
    assign y_ext  = {1'b0, ball_y};
    assign p1_top = {1'b0, i_Paddle_Y_P1};
    assign p1_bot = p1_top + PAD_SPAN;
    assign p2_top = {1'b0, i_Paddle_Y_P2};
    assign p2_bot = p2_top + PAD_SPAN;
    assign on_p1  = (y_ext >= p1_top) && (y_ext <= p1_bot);
    assign on_p2  = (y_ext >= p2_top) && (y_ext <= p2_bot);

    assign tick = (cnt == (CNT_W'(period) - CNT_W'(1)));

    // Compared in full integer width so the subtraction can never underflow.
    assign period_faster = (int'(period) >= SPEED_MIN + SPEED_STEP) ?
                           (period - PER_STEP) : PER_FLOOR;

    always_comb begin
        state_next    = state;
        ball_x_next   = ball_x;
        ball_y_next   = ball_y;
        dir_x_next    = dir_x;
        dir_y_next    = dir_y;
        period_next   = period;
        cnt_next      = cnt;
        score_p1_next = 1'b0;
        score_p2_next = 1'b0;
        hit_next      = 1'b0;
        draw_next     = (i_Col_Count_Div == ball_x) && (i_Row_Count_Div == ball_y);

        if (!i_Game_Active) begin
            state_next  = IDLE;
            ball_x_next = X_CENTRE;
            ball_y_next = Y_CENTRE;
            period_next = PER_START;
            cnt_next    = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next  = SERVE;
                    ball_x_next = X_CENTRE;
                    ball_y_next = Y_CENTRE;
                    period_next = PER_START;
                    cnt_next    = '0;
                end

                SERVE: begin
                    ball_x_next = X_CENTRE;
                    ball_y_next = Y_CENTRE;
                    period_next = PER_START;
                    if (cnt == SERVE_END) begin
                        state_next = PLAY;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end

                PLAY: begin
                    if (!tick) begin
                        cnt_next = cnt + CNT_W'(1);
                    end else begin
                        cnt_next = '0;

                        if (dir_y && (ball_y == Y_LAST)) begin
                            dir_y_next  = 1'b0;
                            ball_y_next = ball_y - COORD_W'(1);
                        end else if (!dir_y && (ball_y == '0)) begin
                            dir_y_next  = 1'b1;
                            ball_y_next = ball_y + COORD_W'(1);
                        end else if (dir_y) begin
                            ball_y_next = ball_y + COORD_W'(1);
                        end else begin
                            ball_y_next = ball_y - COORD_W'(1);
                        end

                        // Horizontal decisions use the pre-move row, so a
                        // wall bounce and a paddle return can share a tick.
                        if (!dir_x) begin
                            if ((ball_x == X_HIT_L) && on_p1) begin
                                dir_x_next  = 1'b1;
                                ball_x_next = X_RET_L;
                                period_next = period_faster;
                                hit_next    = 1'b1;
                            end else if (ball_x == '0) begin
                                score_p2_next = 1'b1;
                                dir_x_next    = 1'b1;
                                state_next    = SERVE;
                                ball_x_next   = X_CENTRE;
                                ball_y_next   = Y_CENTRE;
                                period_next   = PER_START;
                            end else begin
                                ball_x_next = ball_x - COORD_W'(1);
                            end
                        end else begin
                            if ((ball_x == X_HIT_R) && on_p2) begin
                                dir_x_next  = 1'b0;
                                ball_x_next = X_RET_R;
                                period_next = period_faster;
                                hit_next    = 1'b1;
                            end else if (ball_x == X_LAST) begin
                                score_p1_next = 1'b1;
                                dir_x_next    = 1'b0;
                                state_next    = SERVE;
                                ball_x_next   = X_CENTRE;
                                ball_y_next   = Y_CENTRE;
                                period_next   = PER_START;
                            end else begin
                                ball_x_next = ball_x + COORD_W'(1);
                            end
                        end
                    end
                end

                default: begin
                    state_next  = IDLE;
                    ball_x_next = X_CENTRE;
                    ball_y_next = Y_CENTRE;
                    period_next = PER_START;
                    cnt_next    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state      <= IDLE;
            ball_x     <= X_CENTRE;
            ball_y     <= Y_CENTRE;
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
            period     <= PER_START;
            cnt        <= '0;
            draw_q     <= 1'b0;
            score_p1_q <= 1'b0;
            score_p2_q <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            state      <= state_next;
            ball_x     <= ball_x_next;
            ball_y     <= ball_y_next;
            dir_x      <= dir_x_next;
            dir_y      <= dir_y_next;
            period     <= period_next;
            cnt        <= cnt_next;
            draw_q     <= draw_next;
            score_p1_q <= score_p1_next;
            score_p2_q <= score_p2_next;
            hit_q      <= hit_next;
        end
    end

    assign o_Draw_Ball = draw_q;
    assign o_Ball_X    = ball_x;
    assign o_Ball_Y    = ball_y;
    assign o_Score_P1  = score_p1_q;
    assign o_Score_P2  = score_p2_q;
    assign o_Hit       = hit_q;

endmodule
